alu: RTL and testbench



---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_core.sv | 125 ++++++++++++
 rtl/alu.sv | 55 +++++
 tb/tb_alu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the MIPS-style execute-stage ALU.
//   WIDTH      - datapath width (only 32 is supported)
//   SHAMT_W    - width of the shift amount taken from a[4:0]
//   ALU_*      - 4-bit opcode encodings for the aluc select
//   alu_res_t  - result word plus the four status flags, as one bundle
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  // Opcode encodings. LUI and SLL each occupy two codes; the low bit is
  // a don't-care for those operations.
  localparam logic [3:0] ALU_ADDU    = 4'b0000;
  localparam logic [3:0] ALU_SUBU    = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0011;
  localparam logic [3:0] ALU_AND     = 4'b0100;
  localparam logic [3:0] ALU_OR      = 4'b0101;
  localparam logic [3:0] ALU_XOR     = 4'b0110;
  localparam logic [3:0] ALU_NOR     = 4'b0111;
  localparam logic [3:0] ALU_LUI     = 4'b1000;
  localparam logic [3:0] ALU_LUI_ALT = 4'b1001;
  localparam logic [3:0] ALU_SLTU    = 4'b1010;
  localparam logic [3:0] ALU_SLT     = 4'b1011;
  localparam logic [3:0] ALU_SRA     = 4'b1100;
  localparam logic [3:0] ALU_SRL     = 4'b1101;
  localparam logic [3:0] ALU_SLL     = 4'b1110;
  localparam logic [3:0] ALU_SLL_ALT = 4'b1111;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             zero;
    logic             carry;
    logic             negative;
    logic             overflow;
  } alu_res_t;

  localparam alu_res_t ALU_RES_RESET = '0;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
//   a    - operand A; a[4:0] is the shift amount for shift ops
//   b    - operand B; value shifted for shift ops, LUI source
//   aluc - operation select (see alu_pkg opcodes)
//   res  - result word and zero/carry/negative/overflow flags
module alu_core
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output alu_res_t         res
);

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     srl_ext;
  logic [WIDTH:0]     sra_ext;
  logic [WIDTH:0]     sll_ext;
  logic               lt_signed;
  logic               lt_unsigned;

  // Widen by one bit so the carry out of the adder and the borrow of the
  // subtractor fall out as bit WIDTH. For the difference, bit WIDTH is set
  // exactly when a < b unsigned.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  assign shamt = a[SHAMT_W-1:0];

  // Shifts run on a 33-bit copy of b with a guard bit on the side the data
  // leaves through. After shifting, the guard position holds the last bit
  // shifted out, and it stays 0 for a zero shift amount because the guard
  // starts out clear.
  assign srl_ext = {b, 1'b0} >> shamt;
  assign sra_ext = $signed({b, 1'b0}) >>> shamt;
  assign sll_ext = {1'b0, b} << shamt;

  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = diff_ext[WIDTH];

  logic [WIDTH-1:0] r_calc;
  logic             carry_calc;
  logic             negative_calc;
  logic             overflow_calc;
  logic             known_op;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    r_calc        = '0;
    carry_calc    = 1'b0;
    overflow_calc = 1'b0;
    known_op      = 1'b1;

    unique case (aluc)
      ALU_ADDU: begin
        r_calc     = sum_ext[WIDTH-1:0];
        carry_calc = sum_ext[WIDTH];
      end
      ALU_ADD: begin
        r_calc        = sum_ext[WIDTH-1:0];
        carry_calc    = sum_ext[WIDTH];
        // Like-signed operands producing an opposite-signed sum.
        overflow_calc = (a[WIDTH-1] == b[WIDTH-1]) &&
                        (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUBU: begin
        r_calc     = diff_ext[WIDTH-1:0];
        carry_calc = lt_unsigned;
      end
      ALU_SUB: begin
        r_calc        = diff_ext[WIDTH-1:0];
        carry_calc    = lt_unsigned;
        // Unlike-signed operands with a difference whose sign left a's.
        overflow_calc = (a[WIDTH-1] != b[WIDTH-1]) &&
                        (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: r_calc = a & b;
      ALU_OR:  r_calc = a | b;
      ALU_XOR: r_calc = a ^ b;
      ALU_NOR: r_calc = ~(a | b);
      ALU_LUI, ALU_LUI_ALT: begin
        r_calc = {b[15:0], 16'h0000};
      end
      ALU_SLT: begin
        r_calc = {{(WIDTH-1){1'b0}}, lt_signed};
      end
      ALU_SLTU: begin
        r_calc     = {{(WIDTH-1){1'b0}}, lt_unsigned};
        carry_calc = lt_unsigned;
      end
      ALU_SRA: begin
        r_calc     = sra_ext[WIDTH:1];
        carry_calc = sra_ext[0];
      end
      ALU_SRL: begin
        r_calc     = srl_ext[WIDTH:1];
        carry_calc = srl_ext[0];
      end
      ALU_SLL, ALU_SLL_ALT: begin
        r_calc     = sll_ext[WIDTH-1:0];
        carry_calc = sll_ext[WIDTH];
      end
      default: begin
        known_op = 1'b0;
      end
    endcase

    // SLT reports the comparison on the sign flag; everything else uses
    // the result's top bit (which is 0 for SLT's 0/1 result anyway).
    negative_calc = (aluc == ALU_SLT) ? lt_signed : r_calc[WIDTH-1];
  end

  always_comb begin
    res          = ALU_RES_RESET;
    res.r        = r_calc;
    res.zero     = known_op && (r_calc == '0);
    res.carry    = known_op && carry_calc;
    res.negative = known_op && negative_calc;
    res.overflow = known_op && overflow_calc;
  end

endmodule : alu_core

// File: rtl/alu.sv
// alu: 32-bit MIPS-style integer ALU with one output pipeline register.
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset, clears all outputs
//   a, b     - operands (a[4:0] is the shift amount for shifts)
//   aluc     - operation select
//   r        - registered result, valid the cycle after the inputs
//   zero, carry, negative, overflow - registered status flags
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow
);

  alu_res_t core_res;
  alu_res_t res_d;
  alu_res_t res_q;

  alu_core u_core (
    .a    (a),
    .b    (b),
    .aluc (aluc),
    .res  (core_res)
  );

  // A new operation is taken every cycle; there is no enable or handshake.
  always_comb begin
    res_d = core_res;
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples its input from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= ALU_RES_RESET;
    end else begin
      res_q <= res_d;
    end
  end

  assign r        = res_q.r;
  assign zero     = res_q.zero;
  assign carry    = res_q.carry;
  assign negative = res_q.negative;
  assign overflow = res_q.overflow;

endmodule : alu

// File: tb/tb_alu.sv
// tb_alu: randomized self-checking bench for alu. Directed vectors with
// hand-derived expectations, reset behaviour, then random operations
// compared against an arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluc;
  logic [31:0] r;
  logic        zero;
  logic        carry;
  logic        negative;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .aluc     (aluc),
    .r        (r),
    .zero     (zero),
    .carry    (carry),
    .negative (negative),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        n;
    logic        v;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model: derived from the operation definitions using plain
  // integer arithmetic (64-bit signed range checks for overflow, direct
  // bit indexing for the shifted-out bit).
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t   e;
    longint sx;
    longint sy;
    longint wide;
    int     sh;
    logic   slt_res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(x[4:0]);
    e = '0;
    slt_res = 1'b0;
    case (op)
      4'd0, 4'd2: begin
        e.r  = x + y;
        e.c  = (64'(x) + 64'(y)) > 64'h0000_0000_FFFF_FFFF;
        wide = sx + sy;
        e.v  = (op == 4'd2) && (wide > 64'sd2147483647 || wide < -64'sd2147483648);
      end
      4'd1, 4'd3: begin
        e.r  = x - y;
        e.c  = x < y;
        wide = sx - sy;
        e.v  = (op == 4'd3) && (wide > 64'sd2147483647 || wide < -64'sd2147483648);
      end
      4'd4: e.r = x & y;
      4'd5: e.r = x | y;
      4'd6: e.r = x ^ y;
      4'd7: e.r = ~(x | y);
      4'd8, 4'd9: e.r = y * 32'h0001_0000;
      4'd10: begin
        e.r = (x < y) ? 32'd1 : 32'd0;
        e.c = x < y;
      end
      4'd11: begin
        slt_res = sx < sy;
        e.r = slt_res ? 32'd1 : 32'd0;
      end
      4'd12: begin
        e.r = 32'($signed(y) >>> sh);
        e.c = (sh == 0) ? 1'b0 : y[sh-1];
      end
      4'd13: begin
        e.r = y >> sh;
        e.c = (sh == 0) ? 1'b0 : y[sh-1];
      end
      default: begin
        e.r = y << sh;
        e.c = (sh == 0) ? 1'b0 : y[32-sh];
      end
    endcase
    e.z = (e.r == 32'd0);
    e.n = (op == 4'd11) ? slt_res : e.r[31];
    return e;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk);
    aluc = op;
    a    = x;
    b    = y;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".r"}, r, e.r);
    check({tag, ".zero"}, 32'(zero), 32'(e.z));
    check({tag, ".carry"}, 32'(carry), 32'(e.c));
    check({tag, ".negative"}, 32'(negative), 32'(e.n));
    check({tag, ".overflow"}, 32'(overflow), 32'(e.v));
  endtask

  task automatic directed(input string tag, input logic [3:0] op,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic ez,
                          input logic ec, input logic en, input logic ev);
    exp_t e;
    drive(op, x, y);
    e.r = er; e.z = ez; e.c = ec; e.n = en; e.v = ev;
    check_all(tag, e);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  exp_t e_zero;

  initial begin
    e_zero = '0;
    rst_n = 1'b0;
    aluc  = 4'b0010;
    a     = 32'h7FFF_FFFF;
    b     = 32'h0000_0001;
    #1;
    check_all("reset_t0", e_zero);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset_clocked", e_zero);
    @(negedge clk);
    rst_n = 1'b1;

    directed("add_carry",  4'b0010, 32'hFFFF_FFF1, 32'hFFFF_FFEF, 32'hFFFF_FFE0, 0, 1, 1, 0);
    directed("add_ovf",    4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 1);
    directed("subu_borrow",4'b0001, 32'h0000_0005, 32'h0000_000A, 32'hFFFF_FFFB, 0, 1, 1, 0);
    directed("sub_zero",   4'b0011, 32'h0000_0014, 32'h0000_0014, 32'h0000_0000, 1, 0, 0, 0);
    directed("and",        4'b0100, 32'h8888_888E, 32'h48C9_888E, 32'h0888_888E, 0, 0, 0, 0);
    directed("or",         4'b0101, 32'h8888_888E, 32'h48C9_888E, 32'hC8C9_888E, 0, 0, 1, 0);
    directed("xor",        4'b0110, 32'h8888_888E, 32'h48C9_888E, 32'hC041_0000, 0, 0, 1, 0);
    directed("nor",        4'b0111, 32'h8888_888E, 32'h48C9_888E, 32'h3736_7771, 0, 0, 0, 0);
    directed("lui",        4'b1000, 32'h8888_888E, 32'h0000_0001, 32'h0001_0000, 0, 0, 0, 0);
    directed("slt",        4'b1011, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1, 0, 0, 0);
    directed("sltu",       4'b1010, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 0, 0);
    directed("srl",        4'b1101, 32'h0000_0005, 32'h0701_FE03, 32'h0038_0FF0, 0, 0, 0, 0);
    directed("sll",        4'b1111, 32'h0000_0005, 32'h0701_FE03, 32'hE03F_C060, 0, 0, 1, 0);
    directed("sra",        4'b1100, 32'h0000_0004, 32'h8000_0010, 32'hF800_0001, 0, 0, 1, 0);
    directed("srl_out1",   4'b1101, 32'hFFFF_FFE1, 32'h0000_0001, 32'h0000_0000, 1, 1, 0, 0);
    directed("sll_out1",   4'b1110, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1, 1, 0, 0);
    directed("sra_sh0",    4'b1100, 32'h0000_0000, 32'h8000_0001, 32'h8000_0001, 0, 0, 1, 0);

    // Asynchronous reset between edges, then release and capture.
    drive(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    check("pre_reset.r", r, 32'h8000_0000);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", e_zero);
    aluc = 4'b0000;
    a    = 32'h0000_0003;
    b    = 32'h0000_0004;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("after_release", e_zero);
    @(posedge clk);
    #1;
    check_all("first_capture", model(4'b0000, 32'h3, 32'h4));

    for (int i = 0; i < 1500; i++) begin
      logic [3:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      op = 4'($urandom_range(0, 15));
      x  = pick_operand();
      y  = pick_operand();
      drive(op, x, y);
      check_all($sformatf("rand%0d_op%0h", i, op), model(op, x, y));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu
